// File: rtl/sc_serial_register_rx_pkg.sv
// rtl/sc_serial_register_rx_pkg.sv - shared types, constants and helpers for the SC serial-register receiver
package sc_serial_register_rx_pkg;

   localparam int         SC_PKT_BITS = 32;
   localparam logic [7:0] SC_CHK_SEED = 8'hA5;

   typedef struct packed {
      logic        wr;
      logic [6:0]  addr;
      logic [15:0] data;
      logic [7:0]  chk;
   } sc_cmd_t;

   typedef enum logic {
      R_IDLE,
      R_SHIFT
   } sc_rx_state_t;

   typedef enum logic [1:0] {
      C_IDLE,
      C_WRITE,
      C_READ,
      C_RESP
   } sc_cmd_state_t;

   function automatic logic [7:0] sc_checksum(input logic [23:0] body);
      return body[23:16] ^ body[15:8] ^ body[7:0] ^ SC_CHK_SEED;
   endfunction

   function automatic logic [15:0] sc_sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/sc_frame_serializer.sv
// rtl/sc_frame_serializer.sv - shifts a 32-bit response word into the TX SC field, one bit per TX strobe
module sc_frame_serializer
   import sc_serial_register_rx_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic [31:0] i_data,
   input  logic        tx_strobe_i,
   output logic [3:0]  tx_sc_o,
   output logic        o_last
);

   logic [31:0] r_sr;
   logic [5:0]  r_left;
   logic        r_first;

   assign o_last = tx_strobe_i && (r_left == 6'd1);

   // A strobe in the load cycle still acts on the old (empty) state, so it drives 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sr    <= '0;
         r_left  <= '0;
         r_first <= 1'b0;
         tx_sc_o <= '0;
      end else begin
         if (tx_strobe_i) begin
            if (r_left != 6'd0) begin
               tx_sc_o <= {2'b00, r_first, r_sr[31]};
               r_sr    <= {r_sr[30:0], 1'b0};
               r_left  <= r_left - 6'd1;
               r_first <= 1'b0;
            end else begin
               tx_sc_o <= '0;
            end
         end
         if (i_load) begin
            r_sr    <= i_data;
            r_left  <= 6'(SC_PKT_BITS);
            r_first <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/sc_serial_register_rx.sv
// rtl/sc_serial_register_rx.sv - deserialises SC-field register commands, executes them on the local bus
// and serialises the response into the TX SC field
module sc_serial_register_rx
   import sc_serial_register_rx_pkg::*;
#(
   parameter int ADDR_W         = 7,
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid_i,
   input  logic [3:0]        rx_sc_i,
   input  logic              tx_strobe_i,
   output logic [3:0]        tx_sc_o,
   output logic [ADDR_W-1:0] reg_addr_o,
   output logic [DATA_W-1:0] reg_wdata_o,
   output logic              reg_we_o,
   output logic              reg_re_o,
   input  logic [DATA_W-1:0] reg_rdata_i,
   input  logic              reg_rack_i,
   output logic              busy_o,
   output logic [15:0]       chk_err_cnt_o,
   output logic [15:0]       sync_err_cnt_o,
   output logic [15:0]       ovr_cnt_o,
   output logic [15:0]       tmo_cnt_o
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic w_bit, w_sync, w_unused;
   assign w_bit    = rx_sc_i[0];
   assign w_sync   = rx_sc_i[1];
   assign w_unused = ^rx_sc_i[3:2];

   sc_rx_state_t r_rstate, w_rnext;
   logic [31:0]  r_rx_sr;
   logic [4:0]   r_rx_cnt;
   logic         r_pkt_done;
   logic         w_rx_last;
   logic [15:0]  r_sync_err;

   assign w_rx_last = rx_valid_i && !w_sync && (r_rstate == R_SHIFT)
                      && (r_rx_cnt == 5'(SC_PKT_BITS - 1));

   always_comb begin
      w_rnext = r_rstate;
      case (r_rstate)
         R_IDLE:  if (rx_valid_i && w_sync) w_rnext = R_SHIFT;
         R_SHIFT: if (w_rx_last) w_rnext = R_IDLE;
         default: w_rnext = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_rstate <= R_IDLE;
      else     r_rstate <= w_rnext;
   end

   // A sync bit always restarts the packet; in R_SHIFT it also counts as a sync error.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_sr    <= '0;
         r_rx_cnt   <= '0;
         r_pkt_done <= 1'b0;
         r_sync_err <= '0;
      end else begin
         r_pkt_done <= w_rx_last;
         if (rx_valid_i) begin
            if (w_sync) begin
               r_rx_sr  <= {31'b0, w_bit};
               r_rx_cnt <= 5'd1;
               if (r_rstate == R_SHIFT) r_sync_err <= sc_sat_inc(r_sync_err);
            end else if (r_rstate == R_SHIFT) begin
               r_rx_sr  <= {r_rx_sr[30:0], w_bit};
               r_rx_cnt <= r_rx_cnt + 5'd1;
            end
         end
      end
   end

   sc_cmd_state_t     r_cstate, w_cnext;
   sc_cmd_t           w_pkt;
   logic              r_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [TW-1:0]     r_wait;
   logic              r_re_done, r_resp_loaded;
   logic [15:0]       r_chk_err, r_ovr, r_tmo;
   logic              w_chk_ok, w_free, w_accept, w_ovr, w_chk_bad, w_timeout;
   logic              w_load, w_ser_last;
   logic [23:0]       w_resp_body;
   logic [31:0]       w_resp_word;

   assign w_pkt       = r_rx_sr;
   assign w_chk_ok    = (sc_checksum(r_rx_sr[31:8]) == w_pkt.chk);
   assign w_free      = (r_cstate == C_IDLE) || ((r_cstate == C_RESP) && w_ser_last);
   assign w_accept    = r_pkt_done && w_chk_ok && w_free;
   assign w_ovr       = r_pkt_done && w_chk_ok && !w_free;
   assign w_chk_bad   = r_pkt_done && !w_chk_ok;
   assign w_timeout   = (r_cstate == C_READ) && !reg_rack_i
                        && (r_wait == TW'(TIMEOUT_CYCLES - 1));
   assign w_resp_body = {r_wr, r_addr, r_data};
   assign w_resp_word = {w_resp_body, sc_checksum(w_resp_body)};

   always_comb begin
      w_cnext  = r_cstate;
      w_load   = 1'b0;
      reg_we_o = 1'b0;
      reg_re_o = 1'b0;
      busy_o   = (r_cstate != C_IDLE);
      case (r_cstate)
         C_IDLE: begin
            if (w_accept) w_cnext = w_pkt.wr ? C_WRITE : C_READ;
         end
         C_WRITE: begin
            reg_we_o = 1'b1;
            w_cnext  = C_RESP;
         end
         C_READ: begin
            reg_re_o = !r_re_done;
            if (reg_rack_i || w_timeout) w_cnext = C_RESP;
         end
         C_RESP: begin
            w_load = !r_resp_loaded;
            if (w_ser_last) begin
               if (w_accept) w_cnext = w_pkt.wr ? C_WRITE : C_READ;
               else          w_cnext = C_IDLE;
            end
         end
         default: w_cnext = C_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_cstate <= C_IDLE;
      else     r_cstate <= w_cnext;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr          <= 1'b0;
         r_addr        <= '0;
         r_data        <= '0;
         r_wait        <= '0;
         r_re_done     <= 1'b0;
         r_resp_loaded <= 1'b0;
         r_chk_err     <= '0;
         r_ovr         <= '0;
         r_tmo         <= '0;
      end else begin
         if (w_accept) begin
            r_wr   <= w_pkt.wr;
            r_addr <= w_pkt.addr;
            r_data <= w_pkt.data;
         end
         if (r_cstate == C_READ) begin
            if (reg_rack_i)     r_data <= reg_rdata_i;
            else if (w_timeout) r_data <= 16'hDEAD;
         end
         r_wait        <= (r_cstate == C_READ) ? r_wait + TW'(1) : '0;
         r_re_done     <= (r_cstate == C_READ);
         r_resp_loaded <= (r_cstate == C_RESP) && (w_cnext == C_RESP);
         if (w_chk_bad) r_chk_err <= sc_sat_inc(r_chk_err);
         if (w_ovr)     r_ovr     <= sc_sat_inc(r_ovr);
         if (w_timeout) r_tmo     <= sc_sat_inc(r_tmo);
      end
   end

   sc_frame_serializer u_ser (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_load),
      .i_data      (w_resp_word),
      .tx_strobe_i (tx_strobe_i),
      .tx_sc_o     (tx_sc_o),
      .o_last      (w_ser_last)
   );

   assign reg_addr_o     = r_addr;
   assign reg_wdata_o    = r_data;
   assign chk_err_cnt_o  = r_chk_err;
   assign sync_err_cnt_o = r_sync_err;
   assign ovr_cnt_o      = r_ovr;
   assign tmo_cnt_o      = r_tmo;

endmodule

// File: tb/tb_sc_serial_register_rx.sv
// tb/tb_sc_serial_register_rx.sv - self-checking bench for sc_serial_register_rx
module tb_sc_serial_register_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_valid = 1'b0;
   logic [3:0]  rx_sc = 4'd0;
   logic        tx_strobe = 1'b0;
   logic [3:0]  tx_sc;
   logic [6:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic        reg_we, reg_re;
   logic [15:0] reg_rdata = 16'd0;
   logic        reg_rack = 1'b0;
   logic        busy;
   logic [15:0] chk_cnt, sync_cnt, ovr_cnt, tmo_cnt;

   sc_serial_register_rx dut (
      .clk            (clk),
      .rst            (rst),
      .rx_valid_i     (rx_valid),
      .rx_sc_i        (rx_sc),
      .tx_strobe_i    (tx_strobe),
      .tx_sc_o        (tx_sc),
      .reg_addr_o     (reg_addr),
      .reg_wdata_o    (reg_wdata),
      .reg_we_o       (reg_we),
      .reg_re_o       (reg_re),
      .reg_rdata_i    (reg_rdata),
      .reg_rack_i     (reg_rack),
      .busy_o         (busy),
      .chk_err_cnt_o  (chk_cnt),
      .sync_err_cnt_o (sync_cnt),
      .ovr_cnt_o      (ovr_cnt),
      .tmo_cnt_o      (tmo_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // TX strobe every fourth clock
   int sdiv = 0;
   always @(posedge clk) begin
      #1;
      sdiv = (sdiv + 1) % 4;
      tx_strobe = (sdiv == 0);
   end

   // TX collector: rebuilds response words from the SC field
   logic [31:0] resp_q[$];
   logic [31:0] col_w = 32'd0;
   int          col_n = 0;
   always @(posedge clk) begin
      if (tx_strobe && !rst) begin
         #2;
         if (tx_sc[1]) begin
            col_w = {31'd0, tx_sc[0]};
            col_n = 1;
         end else if (col_n > 0) begin
            col_w = {col_w[30:0], tx_sc[0]};
            col_n++;
         end
         if (col_n == 32) begin
            resp_q.push_back(col_w);
            col_n = 0;
         end
      end
   end

   // Register-bus responder and monitor
   int          we_cnt = 0, re_cnt = 0;
   logic [6:0]  we_addr = 7'd0;
   logic [15:0] we_data = 16'd0;
   bit          rack_en = 1'b0;
   int          rack_dly = 0, rack_cd = 0;
   logic [15:0] rack_data = 16'd0;
   always @(negedge clk) begin
      if (reg_rack) reg_rack = 1'b0;
      if (rack_cd > 0) begin
         rack_cd--;
         if (rack_cd == 0) begin
            reg_rack  = 1'b1;
            reg_rdata = rack_data;
         end
      end
      if (reg_we) begin
         we_cnt++;
         we_addr = reg_addr;
         we_data = reg_wdata;
      end
      if (reg_re) begin
         re_cnt++;
         if (rack_en) begin
            if (rack_dly == 0) begin
               reg_rack  = 1'b1;
               reg_rdata = rack_data;
            end else begin
               rack_cd = rack_dly;
            end
         end
      end
   end

   task automatic send_pkt(input logic [31:0] w, input int gap, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         rx_valid = 1'b1;
         rx_sc    = {2'($urandom), (i == 0), w[31-i]};
         tick;
         rx_valid = 1'b0;
         rx_sc    = 4'($urandom);
         if (gap > 0) repeat ($urandom_range(gap, 0)) tick;
      end
   endtask

   // Reference model: response word built from the packet rules
   function automatic logic [7:0] m_chk(input logic [31:0] w);
      return w[31:24] ^ w[23:16] ^ w[15:8] ^ 8'hA5;
   endfunction

   function automatic logic [31:0] m_resp(input logic [31:0] pkt, input bit ack, input logic [15:0] rd);
      logic [31:0] r;
      r = pkt;
      if (!pkt[31]) r[23:8] = ack ? rd : 16'hDEAD;
      r[7:0] = m_chk(r);
      return r;
   endfunction

   logic [15:0] exp_chk = 16'd0, exp_tmo = 16'd0, exp_sync = 16'd0, exp_ovr = 16'd0;

   task automatic run_vec(input string nm, input logic [31:0] pkt, input bit ack, input int dly,
                          input logic [15:0] rd, input bit want_resp, input logic [31:0] want);
      int  we0, re0;
      bit  ok;
      ok  = (m_chk(pkt) == pkt[7:0]);
      we0 = we_cnt;
      re0 = re_cnt;
      rack_en   = ack;
      rack_dly  = dly;
      rack_data = rd;
      resp_q.delete();
      send_pkt(pkt, 2, 32);
      if (!ok) exp_chk++;
      else if (!pkt[31] && !ack) exp_tmo++;
      if (want_resp) begin
         for (int i = 0; i < 1500 && resp_q.size() == 0; i++) tick;
         check({nm, "_resp_seen"}, resp_q.size(), 1);
         if (resp_q.size() > 0) check({nm, "_resp"}, resp_q[0], want);
      end else begin
         repeat (150) tick;
         check({nm, "_no_resp"}, {busy, 31'(resp_q.size())}, 0);
      end
      for (int i = 0; i < 200 && busy; i++) tick;
      repeat (8) tick;
      check({nm, "_tx_idle"}, tx_sc, 0);
      check({nm, "_we_cnt"}, we_cnt - we0, (ok && pkt[31]) ? 1 : 0);
      check({nm, "_re_cnt"}, re_cnt - re0, (ok && !pkt[31]) ? 1 : 0);
      if (ok && pkt[31]) check({nm, "_we_addr_data"}, {we_addr, we_data}, {pkt[30:24], pkt[23:8]});
      check({nm, "_counters"}, {chk_cnt, tmo_cnt}, {exp_chk, exp_tmo});
      check({nm, "_sync_ovr"}, {sync_cnt, ovr_cnt}, {exp_sync, exp_ovr});
   endtask

   typedef struct packed {
      logic [31:0] pkt;
      logic        ack;
      logic [7:0]  dly;
      logic [15:0] rd;
      logic        has_resp;
      logic [31:0] resp;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int we0, re0;
      vecs[0] = '{32'h92BEEF66, 1'b0, 8'd0, 16'h0000, 1'b1, 32'h92BEEF66};
      vecs[1] = '{32'h050000A0, 1'b1, 8'd3, 16'h1234, 1'b1, 32'h05123486};
      vecs[2] = '{32'h050000A0, 1'b0, 8'd0, 16'h0000, 1'b1, 32'h05DEADD3};
      vecs[3] = '{32'h92BEEF67, 1'b0, 8'd0, 16'h0000, 1'b0, 32'h0};

      rst = 1'b1;
      repeat (3) tick;
      check("reset_tx_busy", {tx_sc, busy, reg_we, reg_re}, 0);
      check("reset_bus", {reg_addr, reg_wdata}, 0);
      check("reset_counters", {chk_cnt, sync_cnt, ovr_cnt, tmo_cnt}, 0);
      rst = 1'b0;
      repeat (4) tick;

      for (int v = 0; v < 4; v++)
         run_vec($sformatf("vec%0d", v), vecs[v].pkt, vecs[v].ack, int'(vecs[v].dly),
                 vecs[v].rd, vecs[v].has_resp, vecs[v].resp);

      // Sync arrives mid-packet: partial packet aborted, following packet runs normally
      send_pkt(32'hA3C35A5A, 1, 10);
      exp_sync++;
      run_vec("sync_err", 32'h92BEEF66, 1'b0, 0, 16'h0, 1'b1, 32'h92BEEF66);

      for (int r = 0; r < 16; r++) begin
         logic [31:0] p;
         bit          ack;
         logic [15:0] rd;
         p       = $urandom;
         p[7:0]  = m_chk(p);
         if ($urandom_range(5, 0) == 0) p[7:0] = p[7:0] ^ (8'd1 << $urandom_range(7, 0));
         ack     = ($urandom_range(7, 0) != 0);
         rd      = 16'($urandom);
         run_vec($sformatf("rnd%0d", r), p, ack, $urandom_range(5, 0), rd,
                 m_chk(p) == p[7:0], m_resp(p, ack, rd));
      end

      // Overrun during a response, then reset mid-response
      resp_q.delete();
      we0 = we_cnt;
      send_pkt(32'h92BEEF66, 0, 32);
      for (int i = 0; i < 100 && we_cnt == we0; i++) tick;
      check("ovr_first_we", we_cnt - we0, 1);
      re0 = re_cnt;
      send_pkt(32'h050000A0, 0, 32);
      repeat (3) tick;
      check("ovr_cnt", ovr_cnt, exp_ovr + 16'd1);
      check("ovr_busy_no_read", {busy, 31'(re_cnt - re0)}, 32'h80000000);
      rst = 1'b1;
      tick;
      check("rst_mid_tx", {tx_sc, busy}, 0);
      check("rst_mid_counters", {chk_cnt, sync_cnt, ovr_cnt, tmo_cnt}, 0);
      rst   = 1'b0;
      col_n = 0;
      repeat (200) tick;
      check("rst_no_resp", {31'(resp_q.size()), busy}, 0);
      check("rst_dropped_no_read", re_cnt - re0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sc_serial_register_rx.md
Name: sc_serial_register_rx

Overview:
- Consumes the 4-bit SC field (sc_data_b4) of each received GBT frame and deserialises 32-bit serial-register commands.
- Executes each command as a register write or read on a local register bus.
- Serialises a 32-bit response into the SC field of the outgoing GBT frame.
- Sits between the GBT RX frame decoder and the GBT TX frame builder; the motor and memory fields of the frame are not touched.

Parameters:
ADDR_W, 7, register address width, fixed by the packet format.
DATA_W, 16, register data width, fixed by the packet format.
TIMEOUT_CYCLES, 255, clocks to wait for reg_rack_i before answering a read with 16'hDEAD.

Ports:
clk  in  1  design clock; all logic is on its rising edge.
rst  in  1  synchronous, active-high reset.
rx_valid_i  in  1  one-cycle strobe per received GBT frame.
rx_sc_i  in  4  SC field of the RX frame: [0] serial data (MSB first), [1] packet sync (high with the packet's first bit), [3:2] ignored.
tx_strobe_i  in  1  one-cycle strobe per transmitted GBT frame.
tx_sc_o  out  4  SC field for the TX frame: [0] data, [1] sync, [3:2] always 0.
reg_addr_o  out  7  register address.
reg_wdata_o  out  16  write data.
reg_we_o  out  1  one-cycle write pulse.
reg_re_o  out  1  one-cycle read request pulse.
reg_rdata_i  in  16  read data, valid while reg_rack_i is high.
reg_rack_i  in  1  read acknowledge.
busy_o  out  1  command/response FSM is not idle.
chk_err_cnt_o  out  16  checksum-error counter, saturating.
sync_err_cnt_o  out  16  count of packets aborted by sync, saturating.
ovr_cnt_o  out  16  count of packets dropped while busy, saturating.
tmo_cnt_o  out  16  read-timeout counter, saturating.

Behaviour:
- Reset: every output and counter is 0; all FSMs go to idle. Reset mid-packet discards the partial packet and any in-flight response.
- Packet format: [31] write flag, [30:24] address, [23:8] data, [7:0] checksum.
- Checksum: pkt[31:24] ^ pkt[23:16] ^ pkt[15:8] ^ 8'hA5.
- Bits are sampled only in cycles where rx_valid_i is high.
- RX FSM, R_IDLE -> R_SHIFT:
  - In R_IDLE, a bit with sync=1 loads as bit 31 and the FSM enters R_SHIFT with bit count 1. Bits with sync=0 are ignored.
  - In R_SHIFT, sync=1 before the 32nd bit increments sync_err, restarts the packet with that bit as bit 31, and sets the count to 1.
  - On the 32nd bit the FSM returns to R_IDLE and raises an internal pkt_done pulse one cycle later.
- On pkt_done:
  - Bad checksum: increment chk_err; no bus access and no response.
  - Command FSM not idle: increment ovr; the packet is dropped.
  - Otherwise the command is accepted and reg_addr_o is latched.
- Command FSM, C_IDLE -> C_WRITE | C_READ -> C_RESP -> C_IDLE:
  - C_WRITE: reg_we_o high for exactly one cycle, with reg_wdata_o valid; the response data equals the request data.
  - C_READ: reg_re_o high for one cycle, then wait for reg_rack_i. reg_rack_i may arrive in the same cycle as reg_re_o.
  - Read timeout: after TIMEOUT_CYCLES clocks without reg_rack_i, respond with data 16'hDEAD and increment tmo.
  - C_RESP: load a 32-bit response {req flag, addr, data, checksum} with the checksum recomputed. Return to C_IDLE after the 32nd bit has been driven.
- TX serialiser:
  - tx_sc_o is registered and changes only in tx_strobe_i cycles; it holds between strobes.
  - The first strobe after loading drives {sync=1, bit31}. The next 31 strobes drive {sync=0, next bit}. The strobe after the last bit drives 0.
  - In idle, tx_sc_o is 0.
- Simultaneous events:
  - RX keeps running while TX shifts.
  - pkt_done arriving in the same cycle that the command FSM returns to C_IDLE is accepted.
  - rx_valid_i and tx_strobe_i are independent and may coincide.
- Counters stop at 16'hFFFF.
- busy_o is high in every command state other than C_IDLE.

Decomposition:
- Put the following in the shared types package:
  - sc_cmd_t packed struct {wr, addr[6:0], data[15:0], chk[7:0]}.
  - Constants SC_PKT_BITS=32 and SC_CHK_SEED=8'hA5.
  - A sc_checksum() function.
  - Enums for the RX FSM and the command FSM.
- One sub-module: sc_frame_serializer. It takes a load/data interface and tx_strobe_i and produces tx_sc_o.

Test Plan:
- Write: send 0x92BEEF66 with sync on its first bit -> reg_we_o for one cycle with addr 0x12 and wdata 0xBEEF; TX returns 0x92BEEF66 with sync on the first strobe.
- Read: send 0x050000A0 and raise reg_rack_i 3 cycles after reg_re_o with rdata 0x1234 -> response 0x05123486.
- Timeout: send 0x050000A0 with no reg_rack_i -> response 0x05DEADD3 after TIMEOUT_CYCLES; tmo_cnt_o=1.
- Bad checksum: send 0x92BEEF67 -> no reg_we_o, no response, chk_err_cnt_o=1.
- Sync error: sync at bit 10, then a full valid write packet -> sync_err_cnt_o=1 and the second packet executes normally.
- Overrun and reset: a second valid packet during an active response -> ovr_cnt_o=1 and it is dropped. Then assert rst mid-response -> tx_sc_o=0 and all counters are 0 on the next cycle.
